bp_be_retire_track: RTL

- Two-stage shadow pipeline that follows each dispatched instruction through exception collection to the retire point.
- Drives the retire_* inputs of the system pipe / CSR unit: valid, queue-valid, partial, data, exception and special vectors.
- Generates the precise-trap flush to the front of the backend, and injects pending interrupts on the oldest retirable queue instruction.

---
 rtl/bp_be_retire_track_pkg.sv | 22 ++
 rtl/bp_be_retire_track_stage.sv | 33 +++
 rtl/bp_be_retire_track.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bp_be_retire_track_pkg.sv
// Shared types and constants for the backend retire tracker.
// The pipeline slot structure is sized by the package widths below, so the
// top-level parameters must be left at these defaults.
package bp_be_pkg;

    localparam int dpath_width_gp   = 64;
    localparam int exc_width_gp     = 16;
    localparam int special_width_gp = 8;

    // Exception vector bit used to carry an injected interrupt.
    localparam int e_exc_interrupt_bit = 0;

    typedef struct packed {
        logic                        v;
        logic                        queue_v;
        logic                        partial;
        logic [exc_width_gp-1:0]     exc;
        logic [special_width_gp-1:0] special;
        logic [dpath_width_gp-1:0]   data;
    } bp_be_retire_track_stage_s;

endpackage

// File: rtl/bp_be_retire_track_stage.sv
// One slot of the retire shadow pipeline: a register holding a stage entry.
// The kill input clears only the valid bit of the entry being loaded.
import bp_be_pkg::*;

module bp_be_retire_track_stage (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_kill,
    input  bp_be_retire_track_stage_s i_entry,
    output bp_be_retire_track_stage_s o_entry
);

    bp_be_retire_track_stage_s r_entry;
    bp_be_retire_track_stage_s w_next;

    // Next entry is the incoming one with its valid dropped when killed.
    always_comb begin
        w_next   = i_entry;
        w_next.v = i_entry.v & ~i_kill;
    end

    // Load the slot every cycle; the pipeline never stalls.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_entry <= '0;
        end else begin
            r_entry <= w_next;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/bp_be_retire_track.sv
// Backend retire tracker: two-stage shadow pipeline that follows each
// dispatched instruction to the retire point, merges early/late exceptions,
// injects pending interrupts and raises the precise-trap flush.
// Optional macro BP_BE_RETIRE_TRACK_PERF_EN adds saturating retired/killed
// event counters on perf_retired_o / perf_killed_o.
import bp_be_pkg::*;

module bp_be_retire_track #(
    parameter int dpath_width_p   = dpath_width_gp,
    parameter int exc_width_p     = exc_width_gp,
    parameter int special_width_p = special_width_gp
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       dispatch_v_i,
    input  logic                       dispatch_queue_v_i,
    input  logic                       dispatch_partial_i,
    input  logic [exc_width_p-1:0]     early_exc_i,
    input  logic [dpath_width_p-1:0]   s1_data_i,
    input  logic [special_width_p-1:0] s1_special_i,
    input  logic [exc_width_p-1:0]     late_exc_i,
    input  logic                       flush_i,
    input  logic                       irq_pending_i,
    output logic                       retire_v_o,
    output logic                       retire_queue_v_o,
    output logic                       retire_partial_v_o,
    output logic [dpath_width_p-1:0]   retire_data_o,
    output logic [exc_width_p-1:0]     retire_exception_o,
    output logic [special_width_p-1:0] retire_special_o,
    output logic                       flush_o,
    output logic                       instret_o
`ifdef BP_BE_RETIRE_TRACK_PERF_EN
    ,
    output logic [31:0]                perf_retired_o,
    output logic [31:0]                perf_killed_o
`endif
);

    bp_be_retire_track_stage_s w_s1_in;
    bp_be_retire_track_stage_s w_s1;
    bp_be_retire_track_stage_s w_s2_in;
    bp_be_retire_track_stage_s w_s2;

    logic                       w_kill;
    logic                       w_irq_bit;
    logic [exc_width_p-1:0]     w_exc;
    logic [special_width_p-1:0] w_special;

    // A kill from either source has the same single effect on stage 1 and dispatch.
    assign w_kill = flush_i | flush_o;

    // Stage-1 entry is built from dispatch; data and special arrive a cycle later.
    always_comb begin
        w_s1_in         = '0;
        w_s1_in.v       = dispatch_v_i;
        w_s1_in.queue_v = dispatch_queue_v_i;
        w_s1_in.partial = dispatch_partial_i;
        w_s1_in.exc     = early_exc_i;
    end

    // Stage-2 entry carries stage 1 forward and picks up its data and special ops.
    always_comb begin
        w_s2_in         = w_s1;
        w_s2_in.special = s1_special_i;
        w_s2_in.data    = s1_data_i;
    end

    bp_be_retire_track_stage u_stage1 (
        .i_clk     (clk_i),
        .i_reset_n (reset_n_i),
        .i_kill    (w_kill),
        .i_entry   (w_s1_in),
        .o_entry   (w_s1)
    );

    bp_be_retire_track_stage u_stage2 (
        .i_clk     (clk_i),
        .i_reset_n (reset_n_i),
        .i_kill    (w_kill),
        .i_entry   (w_s2_in),
        .o_entry   (w_s2)
    );

    // Interrupts are only taken on a whole architectural instruction.
    assign w_irq_bit = irq_pending_i & w_s2.v & w_s2.queue_v & ~w_s2.partial;

    // Final exception vector merges early, late and interrupt causes.
    always_comb begin
        w_exc = '0;
        if (w_s2.v) begin
            w_exc = w_s2.exc | late_exc_i;
            w_exc[e_exc_interrupt_bit] = w_exc[e_exc_interrupt_bit] | w_irq_bit;
        end
    end

    // A trapping instruction must not perform its special operation.
    assign w_special = (|w_exc) ? '0 : w_s2.special;

    assign retire_v_o         = w_s2.v;
    assign retire_queue_v_o   = w_s2.v & w_s2.queue_v;
    assign retire_partial_v_o = w_s2.v & w_s2.partial;
    assign retire_data_o      = w_s2.data;
    assign retire_exception_o = w_exc;
    assign retire_special_o   = w_special;
    assign flush_o            = w_s2.v & ((|w_exc) | (|w_special));
    assign instret_o          = retire_queue_v_o & ~retire_partial_v_o & ~(|w_exc);

`ifdef BP_BE_RETIRE_TRACK_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_killed_cnt;
    logic [1:0]  w_kill_inc;
    logic [32:0] w_killed_sum;

    // Up to two entries (stage 1 and the incoming dispatch) can die per cycle.
    assign w_kill_inc   = {1'b0, w_s1.v & w_kill} + {1'b0, dispatch_v_i & w_kill};
    assign w_killed_sum = {1'b0, r_killed_cnt} + {31'd0, w_kill_inc};

    // Count committed instructions, holding at the maximum value.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_retired_cnt <= '0;
        end else if (instret_o && (r_retired_cnt != '1)) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    // Count entries dropped by a flush, holding at the maximum value.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_killed_cnt <= '0;
        end else begin
            r_killed_cnt <= w_killed_sum[32] ? '1 : w_killed_sum[31:0];
        end
    end

    assign perf_retired_o = r_retired_cnt;
    assign perf_killed_o  = r_killed_cnt;
`endif

endmodule
